// File: rtl/cpu_pkg.sv
// Shared constants for the single-issue CPU front end.
// Holds the address and instruction widths, the fetch FSM state type, the
// instruction field positions and the branch offset width. The instruction
// decoder uses the same definitions.
package cpu_pkg;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 13;
  localparam int OFF_W   = 4;

  // Instruction field positions
  localparam int DA_LSB = 4;   // DA  = [5:4]
  localparam int BA_LSB = 0;   // BA  = [1:0]
  localparam int BC_BIT = 6;
  localparam int JB_BIT = 10;
  localparam int PL_LSB = 11;  // PL decode = [12:11]

  typedef enum logic [1:0] {IDLE, REQ, HOLD} fetch_state_t;
endpackage

// File: rtl/next_pc_unit.sv
// Combinational next-PC selection.
// Ports: PC (current PC), Instruction (word being accepted), PL/JB/BC
// (decoder controls), Z/N (datapath flags), JumpAddr (register jump target),
// NextPC (selected next PC). Arithmetic wraps modulo 2^PC_W.
module next_pc_unit #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic [PC_W-1:0]    PC,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               PL,
  input  logic               JB,
  input  logic               BC,
  input  logic               Z,
  input  logic               N,
  input  logic [PC_W-1:0]    JumpAddr,
  output logic [PC_W-1:0]    NextPC
);
  import cpu_pkg::*;

  logic [OFF_W-1:0] off;
  logic [PC_W-1:0]  off_sx;
  logic             taken;
  logic             unused_instr;

  // Branch offset is {DA, BA}, a 4-bit two's complement displacement.
  assign off          = {Instruction[DA_LSB+1:DA_LSB], Instruction[BA_LSB+1:BA_LSB]};
  assign off_sx       = {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
  assign taken        = BC ? N : Z;
  assign unused_instr = ^{Instruction[INSTR_W-1:DA_LSB+2], Instruction[DA_LSB-1:BA_LSB+2]};

  always_comb begin
    NextPC = PC + PC_W'(1);
    if (PL) begin
      if (JB)         NextPC = JumpAddr;
      else if (taken) NextPC = PC + off_sx;
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC register, req/ack fetch from instruction memory,
// valid/ready hand-off to the decoder, next-PC update on accept.
// Ports: clk, rst_n (async low); Run; IMemAddr/IMemReq out, IMemAck/IMemData
// in; Instruction/InstrValid out, InstrReady in; PL/JB/BC decoder controls,
// Z/N flags and JumpAddr for next-PC selection. All outputs come from flops.
module instruction_fetch_unit #(
  parameter int                         PC_W     = cpu_pkg::PC_W,
  parameter int                         INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [cpu_pkg::PC_W-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Run,
  output logic [PC_W-1:0]    IMemAddr,
  output logic               IMemReq,
  input  logic               IMemAck,
  input  logic [INSTR_W-1:0] IMemData,
  output logic [INSTR_W-1:0] Instruction,
  output logic               InstrValid,
  input  logic               InstrReady,
  input  logic               PL,
  input  logic               JB,
  input  logic               BC,
  input  logic               Z,
  input  logic               N,
  input  logic [PC_W-1:0]    JumpAddr
);
  import cpu_pkg::*;

  fetch_state_t        state, state_nxt;
  logic [PC_W-1:0]     pc, next_pc;
  logic [INSTR_W-1:0]  instr;
  logic                accept;

  assign accept = (state == HOLD) && InstrReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Run) state_nxt = REQ;
      REQ:     if (IMemAck) state_nxt = HOLD;
      HOLD:    if (InstrReady) state_nxt = Run ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next state so they change
  // exactly with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= PC_W'(RESET_PC);
      instr      <= '0;
      IMemReq    <= 1'b0;
      InstrValid <= 1'b0;
    end else begin
      if (state == REQ && IMemAck) instr <= IMemData;
      if (accept)                  pc    <= next_pc;
      IMemReq    <= (state_nxt == REQ);
      InstrValid <= (state_nxt == HOLD);
    end
  end

  next_pc_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_next_pc (
    .PC(pc), .Instruction(instr), .PL(PL), .JB(JB), .BC(BC), .Z(Z), .N(N),
    .JumpAddr(JumpAddr), .NextPC(next_pc)
  );

  assign IMemAddr    = pc;
  assign Instruction = instr;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed cases with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_instruction_fetch_unit;
  logic        clk = 0, rst_n = 0, Run = 0;
  logic [7:0]  IMemAddr, JumpAddr = 0;
  logic        IMemReq, IMemAck = 0, InstrValid, InstrReady = 0;
  logic [12:0] IMemData = 0, Instruction;
  logic        PL = 0, JB = 0, BC = 0, Z = 0, N = 0;

  int total = 0, bad = 0;

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .Run(Run), .IMemAddr(IMemAddr), .IMemReq(IMemReq),
    .IMemAck(IMemAck), .IMemData(IMemData), .Instruction(Instruction),
    .InstrValid(InstrValid), .InstrReady(InstrReady), .PL(PL), .JB(JB), .BC(BC),
    .Z(Z), .N(N), .JumpAddr(JumpAddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase 0 = waiting for Run, 1 = fetch outstanding,
  // 2 = word on offer to decoder.
  int          m_phase;
  int          m_pc;
  logic [12:0] m_instr;

  function automatic int model_next(input int pc, input logic [12:0] ins,
      input logic pl, jb, bc, z, n, input int ja);
    int off, npc;
    off = {ins[5:4], ins[1:0]};
    if (off > 7) off -= 16;
    if (!pl)                  npc = pc + 1;
    else if (jb)              npc = ja;
    else if (bc ? n : z)      npc = pc + off;
    else                      npc = pc + 1;
    return (npc + 256) % 256;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_pc = 0; m_instr = 0;
    end else begin
      case (m_phase)
        0: if (Run) m_phase = 1;
        1: if (IMemAck) begin m_instr = IMemData; m_phase = 2; end
        default: if (InstrReady) begin
          m_pc    = model_next(m_pc, m_instr, PL, JB, BC, Z, N, int'(JumpAddr));
          m_phase = Run ? 1 : 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("req", int'(IMemReq), int'(m_phase == 1));
    chk("valid", int'(InstrValid), int'(m_phase == 2));
    chk("addr", int'(IMemAddr), m_pc);
    chk("instr", int'(Instruction), int'(m_instr));
    chk("req_valid_excl", int'(IMemReq & InstrValid), 0);
  end

  // Starts at a negedge in REQ; ends at the negedge after the accept edge.
  task automatic do_fetch(input logic [12:0] d, input logic pl, jb, bc, z, n,
      input logic [7:0] ja, input int ack_dly, input int rdy_dly);
    repeat (ack_dly) @(negedge clk);
    IMemAck = 1; IMemData = d;
    @(negedge clk);
    IMemAck = 0; IMemData = $urandom;
    repeat (rdy_dly) @(negedge clk);
    PL = pl; JB = jb; BC = bc; Z = z; N = n; JumpAddr = ja; InstrReady = 1;
    @(negedge clk);
    InstrReady = 0; PL = 0; JB = 0; BC = 0; Z = 0; N = 0;
  endtask

  task automatic jump_to(input logic [7:0] a);
    do_fetch(13'h0, 1, 1, 0, 0, 0, a, 0, 0);
    chk("jump_addr", int'(IMemAddr), int'(a));
  endtask

  initial begin
    #1;
    chk("rst_req", int'(IMemReq), 0);
    chk("rst_valid", int'(InstrValid), 0);
    chk("rst_addr", int'(IMemAddr), 0);
    chk("rst_instr", int'(Instruction), 0);
    @(negedge clk); rst_n = 1; Run = 1;
    @(negedge clk);
    chk("first_req", int'(IMemReq), 1);
    // sequential fetch, best-case timing
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", int'(IMemAddr), i);
      do_fetch(13'(i * 37 + 5), 0, 0, 0, 0, 0, 8'h0, 0, 0);
    end
    // slow memory and slow decoder
    do_fetch(13'h1ABC, 0, 0, 0, 0, 0, 8'h0, 3, 2);
    chk("slow_addr", int'(IMemAddr), 5);
    // conditional branches from 0x10
    jump_to(8'h10);
    do_fetch(13'h0032, 1, 0, 0, 1, 0, 8'h0, 0, 0);
    chk("br_taken_neg", int'(IMemAddr), 8'h0E);
    jump_to(8'h10);
    do_fetch(13'h0032, 1, 0, 0, 0, 0, 8'h0, 0, 0);
    chk("br_not_taken", int'(IMemAddr), 8'h11);
    jump_to(8'h10);
    do_fetch(13'h0013, 1, 0, 1, 0, 1, 8'h0, 0, 0);
    chk("br_n_pos", int'(IMemAddr), 8'h17);
    jump_to(8'h20);
    jump_to(8'hA5);
    jump_to(8'hFF);
    do_fetch(13'h0, 0, 0, 0, 0, 0, 8'h0, 0, 0);
    chk("wrap_inc", int'(IMemAddr), 8'h00);
    jump_to(8'hFE);
    do_fetch(13'h0013, 1, 0, 0, 1, 0, 8'h0, 0, 0);
    chk("wrap_branch", int'(IMemAddr), 8'h05);
    // Run dropped during REQ
    Run = 0;
    do_fetch(13'h0777, 0, 0, 0, 0, 0, 8'h0, 1, 0);
    chk("stop_req", int'(IMemReq), 0);
    chk("stop_valid", int'(InstrValid), 0);
    chk("stop_addr", int'(IMemAddr), 8'h06);
    repeat (3) @(negedge clk);
    chk("idle_req", int'(IMemReq), 0);
    Run = 1;
    @(negedge clk);
    chk("resume_req", int'(IMemReq), 1);
    chk("resume_addr", int'(IMemAddr), 8'h06);
    // reset in the middle of HOLD
    IMemAck = 1; IMemData = 13'h1FFF;
    @(negedge clk);
    IMemAck = 0;
    chk("hold_valid", int'(InstrValid), 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", int'(InstrValid), 0);
    chk("mid_rst_req", int'(IMemReq), 0);
    chk("mid_rst_instr", int'(Instruction), 0);
    chk("mid_rst_addr", int'(IMemAddr), 0);
    @(negedge clk);
    IMemAck = 1; IMemData = 13'h0ABC; rst_n = 1;
    @(negedge clk);
    IMemAck = 0;
    chk("late_ack_req", int'(IMemReq), 1);
    chk("late_ack_valid", int'(InstrValid), 0);
    chk("late_ack_addr", int'(IMemAddr), 0);
    do_fetch(13'h0042, 0, 0, 0, 0, 0, 8'h0, 0, 0);
    chk("post_rst_addr", int'(IMemAddr), 1);
    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      Run        = ($urandom_range(0, 9) != 0);
      IMemAck    = $urandom_range(0, 1);
      IMemData   = 13'($urandom);
      InstrReady = $urandom_range(0, 1);
      PL = $urandom_range(0, 1); JB = $urandom_range(0, 1);
      BC = $urandom_range(0, 1); Z = $urandom_range(0, 1); N = $urandom_range(0, 1);
      JumpAddr = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 0;
        @(negedge clk);
        rst_n = 1;
      end
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
